// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions, common with the digit-to-segment encoder.
// Patterns are active high in abc_defg order (bit 6 = a, bit 0 = g).
package sevenseg_pkg;

   localparam int SEG_W = 7;
   localparam logic [3:0] BCD_INVALID = 4'hF;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } stab_state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational segment-pattern to BCD decoder; exact matches only.
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [SEG_W-1:0] segments,
   output logic [3:0]       digit,
   output logic             err
);

   always_comb begin
      err = 1'b0;
      unique case (segments)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: begin
            digit = BCD_INVALID;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures a multiplexed seven-segment bus back into BCD digits, waiting for
// each digit to be stable, and emits complete frames with a one-cycle strobe.
module sevenseg_capture
   import sevenseg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEG_W-1:0]      segments,
   input  logic [DIGITS-1:0]     digit_sel,
   output logic [4*DIGITS-1:0]   value,
   output logic                  valid,
   output logic                  frame_err
);

   localparam int SW = DIGITS + SEG_W;
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);

   logic [SW-1:0]         samp;
   logic [CW-1:0]         cnt;
   stab_state_t           state;
   logic [4*DIGITS-1:0]   slots, slots_next;
   logic [DIGITS-1:0]     errs, errs_next;
   logic [DIGITS-1:0]     captured, cap_next;
   logic [3:0]            dec_digit;
   logic                  dec_err;
   logic                  same, one_hot, write, frame_done;

   sevenseg_decode u_decode (
      .segments (segments),
      .digit    (dec_digit),
      .err      (dec_err)
   );

   assign same    = ({digit_sel, segments} == samp);
   assign one_hot = $onehot(digit_sel);
   // cnt sits at STABLE_CYCLES-2 on the edge before acceptance, so the write
   // lands on the edge where cnt becomes STABLE_CYCLES-1.
   assign write   = same && one_hot && (state != HELD) && (cnt == CNT_LAST);

   always_comb begin
      slots_next = slots;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (digit_sel[i]) slots_next[4*i +: 4] = dec_digit;
      end
      errs_next  = (errs & ~digit_sel) | (dec_err ? digit_sel : '0);
      cap_next   = captured | digit_sel;
      frame_done = write && (&cap_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp      <= '0;
         cnt       <= '0;
         state     <= WAIT;
         slots     <= '0;
         errs      <= '0;
         captured  <= '0;
         value     <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         samp  <= {digit_sel, segments};
         valid <= 1'b0;

         if (!same || !one_hot) begin
            state <= WAIT;
            cnt   <= '0;
         end else if (state != HELD) begin
            state <= (cnt == CNT_LAST) ? HELD : COUNT;
            cnt   <= cnt + 1'b1;
         end

         if (write) begin
            slots <= slots_next;
            if (frame_done) begin
               value     <= slots_next;
               frame_err <= |errs_next;
               valid     <= 1'b1;
               captured  <= '0;
               errs      <= '0;
            end else begin
               captured  <= cap_next;
               errs      <= errs_next;
            end
         end
      end
   end

endmodule
